imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
Sequencer for the instruction memory and fetch stage. Receives a byte stream from the debug/UART unit, packs it into 32-bit words and writes them to consecutive instruction-memory word addresses. Gates the CPU (PC/pipeline advance) for free-run or single-step execution until the pipeline reports HALT. Sits between the debug unit, the instruction memory write port and the PC enable.

Parameters:
ADDR_W, 8, instruction memory word-address width (256 words)
HALT_WORD, 32'hFFFF_FFFF, end-of-program marker; also the instruction the pipeline flags as halt

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous, active-low reset
i_cmd_valid  in  1  one-cycle command strobe
i_cmd  in  2  00 LOAD, 01 RUN, 10 STEP, 11 ABORT
i_byte_valid  in  1  one-cycle byte strobe
i_byte  in  8  program byte
i_cpu_halt  in  1  pipeline retired HALT_WORD (level)
o_mem_we  out  1  instruction memory write enable
o_mem_waddr  out  ADDR_W  word address
o_mem_wdata  out  32  word to write
o_cpu_en  out  1  PC/pipeline advance enable
o_pc_clear  out  1  one-cycle PC clear
o_load_done  out  1  one-cycle pulse, program load finished
o_overflow  out  1  sticky: memory filled without HALT_WORD
o_word_count  out  ADDR_W+1  words written in last/current load
o_state  out  3  current state, debug visibility

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; every output 0; byte counter 0; assembly register 0.
- All outputs registered. Commands and bytes are sampled on the rising i_clk edge.
- States: IDLE, LOAD, RUN, STEP, DONE.
- IDLE:
  - LOAD -> LOAD. Same edge: o_pc_clear=1 for one cycle; clear o_word_count, byte counter, o_overflow.
  - RUN -> RUN.
  - STEP -> STEP.
  - ABORT -> no effect.
- LOAD:
  - o_cpu_en=0.
  - Each i_byte_valid shifts the byte in, big-endian: first byte is bits[31:24].
  - On the 4th byte, at the next edge: o_mem_we=1 for one cycle, o_mem_waddr=o_word_count[ADDR_W-1:0], o_mem_wdata=word, and o_word_count increments by 1.
  - If the word equals HALT_WORD: it is still written; o_load_done pulses together with o_mem_we; next state IDLE.
  - If the written word was at address 2^ADDR_W-1 and is not HALT_WORD: o_overflow=1, o_load_done pulses, next state IDLE. No address wrap-around ever occurs.
  - Any command other than ABORT is ignored. ABORT -> IDLE, partial word discarded, no write, no o_load_done.
  - Byte and command in the same cycle: the command wins and the byte is dropped.
- RUN:
  - o_cpu_en=1 from the edge after entry.
  - i_cpu_halt sampled high -> DONE; o_cpu_en=0 from that edge.
  - ABORT -> IDLE, o_cpu_en=0.
  - LOAD/RUN/STEP ignored.
- STEP:
  - o_cpu_en=1 for exactly one cycle, then IDLE.
  - If i_cpu_halt is high during that cycle -> DONE.
  - Commands ignored, except ABORT -> IDLE.
- DONE:
  - o_cpu_en=0. RUN/STEP ignored. LOAD -> LOAD, same as from IDLE. ABORT -> IDLE.
- i_byte_valid outside LOAD is ignored.
- o_word_count holds its value after a load; it is cleared only at LOAD entry or reset.
- i_rst_n asserted mid-load or mid-run: immediate return to reset values. Memory contents are not touched.

Decomposition:
- Package imem_ctrl_pkg: state encoding (IDLE=0, LOAD=1, RUN=2, STEP=3, DONE=4), command codes, HALT_WORD default.
- Sub-module word_assembler: byte counter plus 32-bit shift register. Inputs: i_clk, i_rst_n, clear, byte strobe, byte. Outputs: word, one-cycle word_valid.
- The top level holds the FSM and the address/count logic.

Test Plan:
- LOAD, then bytes 00 00 00 01, 00 00 00 02, FF FF FF FF -> writes (0,0x00000001), (1,0x00000002), (2,0xFFFFFFFF); o_load_done coincides with the third write; o_word_count=3; state IDLE.
- LOAD, 2 bytes, ABORT, then LOAD and 4 bytes 12 34 56 78 -> no write after the abort; next write is addr 0, data 0x12345678; o_pc_clear pulses twice.
- ADDR_W=2, LOAD, 16 non-halt bytes -> writes to addrs 0..3; o_overflow=1 and o_load_done after addr 3; further bytes produce no writes.
- After a load, RUN, i_cpu_halt high 10 cycles later -> o_cpu_en high exactly 10 cycles, then 0; state DONE; a STEP in DONE has no effect.
- After a load, STEP three times, 5 cycles apart -> three single-cycle o_cpu_en pulses; LOAD while in RUN is ignored.
- i_rst_n low mid-word during LOAD -> all outputs 0 immediately; bytes after release produce no writes until a new LOAD.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared constants for the instruction-memory load controller.
//   - FSM state encoding (also exported on o_state for debug)
//   - debug-unit command codes
//   - default end-of-program / halt instruction word
package imem_ctrl_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_STEP = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into 32-bit big-endian words (first byte -> [31:24]).
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   clear          : drop any partial word, restart at byte 0
//   byte_valid     : byte strobe (already qualified by the caller)
//   byte_in        : program byte
//   word           : assembled word, meaningful while word_valid is high
//   word_valid     : high in the cycle the 4th byte of a word is presented
module word_assembler (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt;
    logic [23:0] shreg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt   <= 2'd0;
            shreg <= 24'd0;
        end else if (clear) begin
            cnt   <= 2'd0;
            shreg <= 24'd0;
        end else if (byte_valid) begin
            cnt   <= cnt + 2'd1;
            shreg <= {shreg[15:0], byte_in};
        end
    end

    // The 4th byte is merged combinationally so the caller can register the
    // memory write on the same edge that samples that byte.
    assign word       = {shreg, byte_in};
    assign word_valid = byte_valid && !clear && (cnt == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load / CPU gating sequencer.
// Loads a byte stream from the debug unit into consecutive instruction
// memory words, then gates the PC/pipeline for free-run or single-step
// execution until the pipeline reports HALT.
// Ports:
//   i_clk, i_rst_n           : clock, async active-low reset
//   i_cmd_valid, i_cmd       : command strobe / code (LOAD, RUN, STEP, ABORT)
//   i_byte_valid, i_byte     : program byte stream
//   i_cpu_halt               : pipeline retired the halt word (level)
//   o_mem_we/waddr/wdata     : instruction memory write port
//   o_cpu_en                 : PC/pipeline advance enable
//   o_pc_clear               : one-cycle PC clear at load start
//   o_load_done              : one-cycle pulse at load completion
//   o_overflow               : sticky, memory filled without a halt word
//   o_word_count             : words written in the last/current load
//   o_state                  : FSM state for debug
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    input  logic              i_cpu_halt,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_en,
    output logic              o_pc_clear,
    output logic              o_load_done,
    output logic              o_overflow,
    output logic [ADDR_W:0]   o_word_count,
    output logic [2:0]        o_state
);

    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]  state;
    logic        cmd_load, cmd_run, cmd_step, cmd_abort;
    logic        asm_clear, asm_byte_valid;
    logic [31:0] asm_word;
    logic        asm_word_valid;

    assign cmd_load  = i_cmd_valid && (i_cmd == CMD_LOAD);
    assign cmd_run   = i_cmd_valid && (i_cmd == CMD_RUN);
    assign cmd_step  = i_cmd_valid && (i_cmd == CMD_STEP);
    assign cmd_abort = i_cmd_valid && (i_cmd == CMD_ABORT);

    // A byte that collides with any command is dropped, even an ignored one.
    assign asm_byte_valid = i_byte_valid && (state == ST_LOAD) && !i_cmd_valid;

    // Restart assembly on load entry and throw away a partial word on abort.
    assign asm_clear = (((state == ST_IDLE) || (state == ST_DONE)) && cmd_load) ||
                       ((state == ST_LOAD) && cmd_abort);

    word_assembler u_asm (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .clear      (asm_clear),
        .byte_valid (asm_byte_valid),
        .byte_in    (i_byte),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            o_mem_we     <= 1'b0;
            o_mem_waddr  <= '0;
            o_mem_wdata  <= 32'd0;
            o_cpu_en     <= 1'b0;
            o_pc_clear   <= 1'b0;
            o_load_done  <= 1'b0;
            o_overflow   <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_mem_we    <= 1'b0;
            o_pc_clear  <= 1'b0;
            o_load_done <= 1'b0;

            case (state)
                ST_IDLE, ST_DONE: begin
                    o_cpu_en <= 1'b0;
                    if (cmd_load) begin
                        state        <= ST_LOAD;
                        o_pc_clear   <= 1'b1;
                        o_word_count <= '0;
                        o_overflow   <= 1'b0;
                    end else if (cmd_abort) begin
                        state <= ST_IDLE;
                    end else if (state == ST_IDLE && cmd_run) begin
                        // Enable follows one edge after entering RUN.
                        state <= ST_RUN;
                    end else if (state == ST_IDLE && cmd_step) begin
                        // The single enable cycle starts right at entry.
                        state    <= ST_STEP;
                        o_cpu_en <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    o_cpu_en <= 1'b0;
                    if (cmd_abort) begin
                        state <= ST_IDLE;
                    end else if (asm_word_valid) begin
                        o_mem_we     <= 1'b1;
                        o_mem_waddr  <= o_word_count[ADDR_W-1:0];
                        o_mem_wdata  <= asm_word;
                        o_word_count <= o_word_count + ONE;
                        if (asm_word == HALT_WORD) begin
                            o_load_done <= 1'b1;
                            state       <= ST_IDLE;
                        end else if (o_word_count == LAST_ADDR) begin
                            // Top word written without a halt: stop, never wrap.
                            o_overflow  <= 1'b1;
                            o_load_done <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end

                ST_RUN: begin
                    if (cmd_abort) begin
                        state    <= ST_IDLE;
                        o_cpu_en <= 1'b0;
                    end else if (i_cpu_halt) begin
                        state    <= ST_DONE;
                        o_cpu_en <= 1'b0;
                    end else begin
                        o_cpu_en <= 1'b1;
                    end
                end

                ST_STEP: begin
                    o_cpu_en <= 1'b0;
                    if (!cmd_abort && i_cpu_halt) state <= ST_DONE;
                    else                          state <= ST_IDLE;
                end

                default: begin
                    state    <= ST_IDLE;
                    o_cpu_en <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: two instances (256-word and 4-word memories)
// share one stimulus stream; a negedge monitor records writes and pulses,
// and each scenario compares them to what the load/run rules predict.
module tb_imem_load_ctrl;
    import imem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_val = 8'd0;
    logic        cpu_halt = 1'b0;

    logic        we_a, en_a, pcc_a, done_a, ovf_a;
    logic [7:0]  waddr_a;
    logic [31:0] wdata_a;
    logic [8:0]  wc_a;
    logic [2:0]  st_a;

    logic        we_b, en_b, pcc_b, done_b, ovf_b;
    logic [1:0]  waddr_b;
    logic [31:0] wdata_b;
    logic [2:0]  wc_b;
    logic [2:0]  st_b;

    imem_load_ctrl #(.ADDR_W(8)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_byte_valid(byte_valid), .i_byte(byte_val), .i_cpu_halt(cpu_halt),
        .o_mem_we(we_a), .o_mem_waddr(waddr_a), .o_mem_wdata(wdata_a),
        .o_cpu_en(en_a), .o_pc_clear(pcc_a), .o_load_done(done_a),
        .o_overflow(ovf_a), .o_word_count(wc_a), .o_state(st_a)
    );

    imem_load_ctrl #(.ADDR_W(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_byte_valid(byte_valid), .i_byte(byte_val), .i_cpu_halt(cpu_halt),
        .o_mem_we(we_b), .o_mem_waddr(waddr_b), .o_mem_wdata(wdata_b),
        .o_cpu_en(en_b), .o_pc_clear(pcc_b), .o_load_done(done_b),
        .o_overflow(ovf_b), .o_word_count(wc_b), .o_state(st_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic        done;
        logic        ovf;
    } wr_t;

    wr_t wq[2][$];
    int  en_cnt[2];
    int  rise_cnt[2];
    int  pcc_cnt[2];
    int  done_cnt[2];
    logic en_prev[2];

    always @(negedge clk) begin
        wr_t w;
        if (we_a) begin
            w.addr = int'(waddr_a); w.data = wdata_a; w.done = done_a; w.ovf = ovf_a;
            wq[0].push_back(w);
        end
        if (we_b) begin
            w.addr = int'(waddr_b); w.data = wdata_b; w.done = done_b; w.ovf = ovf_b;
            wq[1].push_back(w);
        end
        if (en_a) en_cnt[0]++;
        if (en_b) en_cnt[1]++;
        if (en_a && !en_prev[0]) rise_cnt[0]++;
        if (en_b && !en_prev[1]) rise_cnt[1]++;
        en_prev[0] = en_a;
        en_prev[1] = en_b;
        if (pcc_a)  pcc_cnt[0]++;
        if (pcc_b)  pcc_cnt[1]++;
        if (done_a) done_cnt[0]++;
        if (done_b) done_cnt[1]++;
    end

    function automatic logic [2:0] st_of(input int d);
        return (d == 0) ? st_a : st_b;
    endfunction

    function automatic int wc_of(input int d);
        return (d == 0) ? int'(wc_a) : int'(wc_b);
    endfunction

    function automatic logic ovf_of(input int d);
        return (d == 0) ? ovf_a : ovf_b;
    endfunction

    function automatic logic en_of(input int d);
        return (d == 0) ? en_a : en_b;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT_WORD_DEF) w = 32'h0;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        for (int d = 0; d < 2; d++) begin
            wq[d].delete();
            en_cnt[d] = 0; rise_cnt[d] = 0; pcc_cnt[d] = 0; done_cnt[d] = 0;
        end
    endtask

    task automatic send_cmd(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_val = b;
        tick();
        byte_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({we_a, waddr_a, wdata_a, en_a, pcc_a, done_a, ovf_a, wc_a, st_a} !== '0) begin
            failures++;
            $display("FAIL reset_a: outputs=%h required all zero",
                     {we_a, waddr_a, wdata_a, en_a, pcc_a, done_a, ovf_a, wc_a, st_a});
        end
        checks++;
        if ({we_b, waddr_b, wdata_b, en_b, pcc_b, done_b, ovf_b, wc_b, st_b} !== '0) begin
            failures++;
            $display("FAIL reset_b: outputs=%h required all zero",
                     {we_b, waddr_b, wdata_b, en_b, pcc_b, done_b, ovf_b, wc_b, st_b});
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Loads a program into both instances and checks writes against the
    // rule: consecutive addresses from 0, stopping after the halt word or
    // once the memory is full.
    task automatic test_load(input logic [31:0] words[$], input string name);
        int   depth[2];
        int   n;
        bit   halt_seen, ovf_exp, fin;
        depth[0] = 256;
        depth[1] = 4;
        clear_mon();
        send_cmd(CMD_LOAD);
        foreach (words[i]) send_word(words[i]);
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            n = 0;
            halt_seen = 0;
            while (n < words.size() && n < depth[d] && !halt_seen) begin
                if (words[n] == HALT_WORD_DEF) halt_seen = 1;
                n++;
            end
            ovf_exp = !halt_seen && (n == depth[d]);
            fin = halt_seen || ovf_exp;

            checks++;
            if (wq[d].size() != n) begin
                failures++;
                $display("FAIL %s_nwrites[%0d]: got %0d required %0d", name, d, wq[d].size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (wq[d][i].addr !== i || wq[d][i].data !== words[i] ||
                        wq[d][i].done !== (fin && i == n - 1) ||
                        wq[d][i].ovf !== (ovf_exp && i == n - 1)) begin
                        failures++;
                        $display("FAIL %s_write[%0d][%0d]: got a=%0d d=%h done=%b ovf=%b required a=%0d d=%h done=%b ovf=%b",
                                 name, d, i, wq[d][i].addr, wq[d][i].data, wq[d][i].done, wq[d][i].ovf,
                                 i, words[i], fin && i == n - 1, ovf_exp && i == n - 1);
                    end
                end
            end
            checks++;
            if (pcc_cnt[d] != 1 || done_cnt[d] != int'(fin)) begin
                failures++;
                $display("FAIL %s_pulses[%0d]: pc_clear=%0d load_done=%0d required 1 and %0d",
                         name, d, pcc_cnt[d], done_cnt[d], int'(fin));
            end
            checks++;
            if (wc_of(d) != n || st_of(d) !== (fin ? ST_IDLE : ST_LOAD) || ovf_of(d) !== ovf_exp) begin
                failures++;
                $display("FAIL %s_final[%0d]: count=%0d state=%0d ovf=%b required %0d %0d %b",
                         name, d, wc_of(d), st_of(d), ovf_of(d), n, fin ? ST_IDLE : ST_LOAD, ovf_exp);
            end
        end
    endtask

    task automatic test_load_basic();
        logic [31:0] words[$];
        words = '{32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF};
        test_load(words, "load_fixed");
        for (int r = 0; r < 3; r++) begin
            words.delete();
            repeat ($urandom_range(0, 2)) words.push_back(rand_word());
            words.push_back(HALT_WORD_DEF);
            test_load(words, "load_rand");
        end
    endtask

    task automatic test_abort();
        logic [31:0] words[$];
        clear_mon();
        send_cmd(CMD_LOAD);
        repeat ($urandom_range(1, 3)) send_byte(8'($urandom));
        send_cmd(CMD_ABORT);
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wq[d].size() != 0 || done_cnt[d] != 0 || pcc_cnt[d] != 1 || st_of(d) !== ST_IDLE) begin
                failures++;
                $display("FAIL abort[%0d]: writes=%0d done=%0d pc_clear=%0d state=%0d required 0 0 1 %0d",
                         d, wq[d].size(), done_cnt[d], pcc_cnt[d], st_of(d), ST_IDLE);
            end
        end
        words = '{32'h1234_5678, 32'hFFFF_FFFF};
        test_load(words, "after_abort");
    endtask

    task automatic test_collision();
        logic [31:0] w;
        w = rand_word();
        clear_mon();
        send_cmd(CMD_LOAD);
        // Byte with a (ignored) command in the same cycle must be dropped.
        byte_valid = 1'b1; byte_val = 8'hA5; cmd_valid = 1'b1; cmd = CMD_RUN;
        tick();
        byte_valid = 1'b0; cmd_valid = 1'b0;
        send_word(w);
        send_word(HALT_WORD_DEF);
        repeat (2) tick();
        checks++;
        if (wq[0].size() != 2 || wq[0][0].data !== w || wq[0][0].addr != 0) begin
            failures++;
            $display("FAIL collision: writes=%0d first=%h required 2 writes, first=%h at 0",
                     wq[0].size(), (wq[0].size() > 0) ? wq[0][0].data : 32'h0, w);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] words[$];
        int          na;
        repeat (4 + $urandom_range(0, 2)) words.push_back(rand_word());
        test_load(words, "overflow");
        na = wq[0].size();
        send_cmd(CMD_ABORT);
        repeat (2) tick();
        checks++;
        if (st_a !== ST_IDLE || done_cnt[0] != 0 || wq[0].size() != na || ovf_a !== 1'b0) begin
            failures++;
            $display("FAIL overflow_abort_a: state=%0d done=%0d writes=%0d ovf=%b required %0d 0 %0d 0",
                     st_a, done_cnt[0], wq[0].size(), ovf_a, ST_IDLE, na);
        end
        checks++;
        if (ovf_b !== 1'b1 || st_b !== ST_IDLE || wq[1].size() != 4) begin
            failures++;
            $display("FAIL overflow_sticky_b: ovf=%b state=%0d writes=%0d required 1 %0d 4",
                     ovf_b, st_b, wq[1].size(), ST_IDLE);
        end
    endtask

    task automatic test_run(input int n);
        clear_mon();
        send_cmd(CMD_RUN);
        for (int k = 0; k <= n; k++) begin
            if (k == n) cpu_halt = 1'b1;
            if (k == n / 2) begin cmd_valid = 1'b1; cmd = CMD_LOAD; end
            tick();
            cmd_valid = 1'b0;
        end
        cpu_halt = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (en_cnt[d] != n || rise_cnt[d] != 1 || st_of(d) !== ST_DONE ||
                en_of(d) !== 1'b0 || pcc_cnt[d] != 0) begin
                failures++;
                $display("FAIL run[%0d]: en_cycles=%0d pulses=%0d state=%0d en=%b pc_clear=%0d required %0d 1 %0d 0 0",
                         d, en_cnt[d], rise_cnt[d], st_of(d), en_of(d), pcc_cnt[d], n, ST_DONE);
            end
        end
        send_cmd(CMD_STEP);
        repeat (2) tick();
        send_cmd(CMD_RUN);
        repeat (3) tick();
        checks++;
        if (en_cnt[0] != n || st_a !== ST_DONE) begin
            failures++;
            $display("FAIL done_ignore: en_cycles=%0d state=%0d required %0d %0d",
                     en_cnt[0], st_a, n, ST_DONE);
        end
        send_cmd(CMD_ABORT);
        tick();
        checks++;
        if (st_a !== ST_IDLE || st_b !== ST_IDLE) begin
            failures++;
            $display("FAIL done_abort: state=%0d/%0d required %0d", st_a, st_b, ST_IDLE);
        end
    endtask

    task automatic test_step();
        logic [31:0] words[$];
        clear_mon();
        for (int s = 0; s < 3; s++) begin
            send_cmd(CMD_STEP);
            repeat (5) tick();
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (en_cnt[d] != 3 || rise_cnt[d] != 3 || st_of(d) !== ST_IDLE) begin
                failures++;
                $display("FAIL step[%0d]: en_cycles=%0d pulses=%0d state=%0d required 3 3 %0d",
                         d, en_cnt[d], rise_cnt[d], st_of(d), ST_IDLE);
            end
        end
        send_cmd(CMD_STEP);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        tick();
        checks++;
        if (st_a !== ST_DONE || en_cnt[0] != 4 || en_a !== 1'b0) begin
            failures++;
            $display("FAIL step_halt: state=%0d en_cycles=%0d en=%b required %0d 4 0",
                     st_a, en_cnt[0], en_a, ST_DONE);
        end
        // Load straight from DONE.
        words = '{rand_word(), HALT_WORD_DEF};
        test_load(words, "load_from_done");
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_cmd(CMD_LOAD);
        send_byte(8'h11);
        send_byte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({we_a, waddr_a, wdata_a, en_a, pcc_a, done_a, ovf_a, wc_a, st_a} !== '0 ||
            {we_b, waddr_b, wdata_b, en_b, pcc_b, done_b, ovf_b, wc_b, st_b} !== '0) begin
            failures++;
            $display("FAIL reset_mid_load: state=%0d/%0d count=%0d required all outputs zero", st_a, st_b, wc_a);
        end
        tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        repeat (2) tick();
        checks++;
        if (wq[0].size() != 0 || wq[1].size() != 0 || st_a !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_no_write: writes=%0d/%0d state=%0d required 0/0 %0d",
                     wq[0].size(), wq[1].size(), st_a, ST_IDLE);
        end
        send_cmd(CMD_RUN);
        repeat (3) tick();
        checks++;
        if (en_a !== 1'b1) begin
            failures++;
            $display("FAIL run_before_reset: en=%b required 1", en_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (en_a !== 1'b0 || st_a !== ST_IDLE || en_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_run: en=%b state=%0d required 0 %0d", en_a, st_a, ST_IDLE);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_mon();
        en_prev[0] = 1'b0;
        en_prev[1] = 1'b0;
        test_reset();
        test_load_basic();
        test_abort();
        test_collision();
        test_overflow();
        test_run(10);
        test_run(int'($urandom_range(2, 15)));
        test_step();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
